player_mover: RTL and testbench
===============================

# player_mover

Horizontal motion controller for the player sprite in the dodge game. Decodes the held PS/2 arrow scan code into left/right motion on a programmable tick. Adds acceleration while a key is held, clamps to the playfield, and supports freeze and restart. Sits between the PS/2 keyboard decoder and the VGA renderer/collision checker, which consume `begin_column`/`end_column`.

## Interface
- `COL_W`, 11: width of column coordinates.
- `TICK_DIV`, 250000: clk cycles per motion tick (>= 2).
- `START_COL`, 340: `begin_column` after reset/restart.
- `SPRITE_W`, 80: sprite width; `end_column = begin_column + SPRITE_W` always.
- `MIN_COL`, 0: leftmost legal `begin_column`.
- `MAX_COL`, 640: rightmost legal `end_column`. Requires `MIN_COL <= START_COL <= MAX_COL - SPRITE_W`.
- `MAX_SPEED`, 4: max columns moved per tick (>= 1).
- `ACCEL_TICKS`, 8: ticks of continuous same-direction hold per speed increment (>= 1).
- `LEFT_CODE`, 8'h6B / `RIGHT_CODE`, 8'h74: arrow scan codes.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `scan_code` in 8: currently held scan code (level). Any other value means no motion.
- `freeze` in 1: level. The top level drives it as `fail | gameover`. Halts motion.
- `restart` in 1: single-cycle pulse. Returns the sprite to start.
- `begin_column` out COL_W: sprite left edge.
- `end_column` out COL_W: sprite right edge.
- `speed` out 3: current step size (0 when not moving).
- `moving` out 1: state is MOVE_L or MOVE_R.
- `at_left` / `at_right` out 1: `begin_column == MIN_COL` / `end_column == MAX_COL`.

## Operation
- Tick counter counts 0..TICK_DIV-1 and wraps. `tick` is asserted for one cycle when the count equals TICK_DIV-1. Period is exactly TICK_DIV cycles.
- States:
  - IDLE: not moving.
  - MOVE_L / MOVE_R: moving left / right.
  - FROZEN: motion halted.
- Priority, evaluated every cycle: `reset` > `restart` > `freeze` > tick logic.
- `reset` or `restart`:
  - `begin_column`=START_COL, `end_column`=START_COL+SPRITE_W.
  - state IDLE, `speed`=0, accel count=0, tick counter=0.
- `freeze`=1:
  - State goes to FROZEN; `speed` and accel count go to 0; position holds.
  - Tick counter keeps running.
  - When `freeze` falls, state goes to IDLE. Motion resumes at the next tick.
- On `tick`, when not frozen:
  - `scan_code==LEFT_CODE`, state != MOVE_L: go to MOVE_L, `speed`=1, accel=0, step 1.
  - `scan_code==LEFT_CODE`, state == MOVE_L: step by the current `speed`. accel+1. When accel reaches ACCEL_TICKS-1 and `speed` < MAX_SPEED: `speed`+1, accel=0. When `speed`==MAX_SPEED, accel saturates.
  - RIGHT_CODE: symmetric, using MOVE_R.
  - Any other code: go to IDLE, `speed`=0, accel=0, position holds.
  - A direction reversal is a fresh entry: speed restarts at 1.
- Stepping and clamping:
  - Left: `begin` = max(`begin` - step, MIN_COL), computed without underflow (compare before subtracting).
  - Right: `begin` = min(`begin` + step, MAX_COL - SPRITE_W).
  - `end_column` is always recomputed as `begin`+SPRITE_W. The two never diverge.
  - At a clamp the state stays MOVE_x and `speed` keeps ramping; position stays pinned.
- `scan_code` changes between ticks are ignored. Only the value sampled on the tick cycle matters.

## Timing
- All outputs are registered. Values after reset are listed under reset above. `speed`=0, `moving`=0.
- A position or speed update occurs on the tick cycle and is visible the next cycle. Latency from key-held to first move is at most TICK_DIV cycles.
- `restart` or `freeze` asserted on a tick cycle: the tick's motion is discarded.
- `reset` mid-hold: the next move after release of reset starts at speed 1.
- Edge flags update the same cycle as the position registers.

## Test plan
- Reset, TICK_DIV=4, hold LEFT_CODE for 1 tick:
  - `begin_column` 340 -> 339, `end_column` 419, `speed`=1, `moving`=1.
  - The update occurs exactly 4 cycles after reset release.
- ACCEL_TICKS=2, MAX_SPEED=4, hold RIGHT_CODE for 8 ticks:
  - Per-tick steps 1,1,2,2,3,3,4,4. `begin` 340 -> 360. `speed` saturates at 4.
- START_COL=2, hold LEFT at speed up to 4:
  - `begin` clamps at 0 with no wrap to 2047. `at_left`=1; `end_column`=80 holds.
- Hold RIGHT until `end_column`=640:
  - `at_right`=1 and position holds.
  - Switching to LEFT makes the next tick's step 1 (`begin` 560 -> 559).
- Assert `freeze` while moving at speed 3:
  - Position holds across 10 ticks, `speed`=0, `moving`=0.
  - After release, the next tick steps 1.
- Assert `restart` at the same cycle as a tick with LEFT held:
  - `begin_column`=340, `end_column`=420, state IDLE, `speed`=0.

Source files
------------

// File: rtl/player_mover.sv
// Horizontal motion controller for the player sprite: turns the held arrow
// scan code into clamped, accelerating left/right steps on a periodic tick.
module player_mover #(
  parameter int         COL_W       = 11,
  parameter int         TICK_DIV    = 250000,
  parameter int         START_COL   = 340,
  parameter int         SPRITE_W    = 80,
  parameter int         MIN_COL     = 0,
  parameter int         MAX_COL     = 640,
  parameter int         MAX_SPEED   = 4,
  parameter int         ACCEL_TICKS = 8,
  parameter logic [7:0] LEFT_CODE   = 8'h6B,
  parameter logic [7:0] RIGHT_CODE  = 8'h74
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       scan_code,
  input  logic             freeze,
  input  logic             restart,
  output logic [COL_W-1:0] begin_column,
  output logic [COL_W-1:0] end_column,
  output logic [2:0]       speed,
  output logic             moving,
  output logic             at_left,
  output logic             at_right
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int ACC_W = $clog2(ACCEL_TICKS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEL_TICKS - 1);
  localparam logic [2:0]       SPD_MAX  = 3'(MAX_SPEED);
  localparam logic [COL_W-1:0] START_V  = COL_W'(START_COL);
  localparam logic [COL_W-1:0] SPR_V    = COL_W'(SPRITE_W);
  localparam logic [COL_W-1:0] MIN_V    = COL_W'(MIN_COL);
  localparam logic [COL_W-1:0] MAX_V    = COL_W'(MAX_COL);
  localparam logic [COL_W-1:0] RLIM_V   = COL_W'(MAX_COL - SPRITE_W);

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R, FROZEN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   accel_q, accel_d;
  logic [2:0]         speed_q, speed_d;
  logic [COL_W-1:0]   begin_q, begin_d;
  logic [COL_W-1:0]   end_q, end_d;
  logic               moving_q, at_left_q, at_right_q;
  logic               tick;
  logic               go_left, go_right;
  logic [COL_W:0]     sum;

  assign tick     = (cnt_q == CNT_LAST);
  assign go_left  = (scan_code == LEFT_CODE);
  assign go_right = (scan_code == RIGHT_CODE);

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    accel_d = accel_q;
    begin_d = begin_q;
    sum     = '0;
    cnt_d   = (restart || tick) ? '0 : cnt_q + 1'b1;
    if (restart) begin
      state_d = IDLE;
      speed_d = '0;
      accel_d = '0;
      begin_d = START_V;
    end else if (freeze) begin
      state_d = FROZEN;
      speed_d = '0;
      accel_d = '0;
    end else if (state_q == FROZEN) begin
      state_d = IDLE;
    end else if (tick) begin
      if (go_left || go_right) begin
        // Same direction continues the ramp; a new direction is a fresh entry.
        if ((go_left && state_q == MOVE_L) || (go_right && state_q == MOVE_R)) begin
          if (accel_q == ACC_LAST && speed_q < SPD_MAX) begin
            speed_d = speed_q + 3'd1;
            accel_d = '0;
          end else if (accel_q != ACC_LAST) begin
            accel_d = accel_q + 1'b1;
          end
        end else begin
          state_d = go_left ? MOVE_L : MOVE_R;
          speed_d = 3'd1;
          accel_d = '0;
        end
        if (go_left) begin
          if ({1'b0, begin_q} < ({1'b0, MIN_V} + (COL_W+1)'(speed_d)))
            begin_d = MIN_V;
          else
            begin_d = begin_q - COL_W'(speed_d);
        end else begin
          sum = {1'b0, begin_q} + (COL_W+1)'(speed_d);
          begin_d = (sum > {1'b0, RLIM_V}) ? RLIM_V : sum[COL_W-1:0];
        end
      end else begin
        state_d = IDLE;
        speed_d = '0;
        accel_d = '0;
      end
    end
    end_d = begin_d + SPR_V;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      speed_q    <= '0;
      accel_q    <= '0;
      begin_q    <= START_V;
      end_q      <= START_V + SPR_V;
      moving_q   <= 1'b0;
      at_left_q  <= (START_V == MIN_V);
      at_right_q <= ((START_V + SPR_V) == MAX_V);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      speed_q    <= speed_d;
      accel_q    <= accel_d;
      begin_q    <= begin_d;
      end_q      <= end_d;
      moving_q   <= (state_d == MOVE_L) || (state_d == MOVE_R);
      at_left_q  <= (begin_d == MIN_V);
      at_right_q <= (end_d == MAX_V);
    end
  end

  assign begin_column = begin_q;
  assign end_column   = end_q;
  assign speed        = speed_q;
  assign moving       = moving_q;
  assign at_left      = at_left_q;
  assign at_right     = at_right_q;

endmodule

// File: tb/tb_player_mover.sv
// Bench for player_mover: directed scenarios plus randomized key/freeze/restart
// traffic against a tick-level behavioural model of two instances.
module tb_player_mover;
  localparam int TD   = 4;
  localparam int ACC  = 2;
  localparam int MAXS = 4;
  localparam logic [7:0] LC = 8'h6B;
  localparam logic [7:0] RC = 8'h74;

  logic clk = 1'b0;
  logic reset, freeze, restart;
  logic [7:0] scan_code;
  logic [10:0] a_begin, a_end, b_begin, b_end;
  logic [2:0]  a_speed, b_speed;
  logic a_moving, a_at_left, a_at_right, b_moving, b_at_left, b_at_right;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  player_mover #(.TICK_DIV(TD), .ACCEL_TICKS(ACC), .MAX_SPEED(MAXS), .START_COL(340)) dut_a (
    .clk(clk), .reset(reset), .scan_code(scan_code), .freeze(freeze), .restart(restart),
    .begin_column(a_begin), .end_column(a_end), .speed(a_speed), .moving(a_moving),
    .at_left(a_at_left), .at_right(a_at_right));

  player_mover #(.TICK_DIV(TD), .ACCEL_TICKS(ACC), .MAX_SPEED(MAXS), .START_COL(2)) dut_b (
    .clk(clk), .reset(reset), .scan_code(scan_code), .freeze(freeze), .restart(restart),
    .begin_column(b_begin), .end_column(b_end), .speed(b_speed), .moving(b_moving),
    .at_left(b_at_left), .at_right(b_at_right));

  // Reference model: position, speed, direction (0 none, 1 left, 2 right),
  // ticks spent at the current speed, and a frozen flag.
  int start_col [2] = '{340, 2};
  int m_pos [2], m_spd [2], m_dir [2], m_n [2], m_frz [2];
  int m_cnt = 0;

  always @(posedge clk) begin
    bit tk;
    int d;
    tk = (m_cnt == TD - 1);
    for (int k = 0; k < 2; k++) begin
      if (reset || restart) begin
        m_pos[k] = start_col[k]; m_spd[k] = 0; m_dir[k] = 0; m_n[k] = 0; m_frz[k] = 0;
      end else if (freeze) begin
        m_frz[k] = 1; m_dir[k] = 0; m_spd[k] = 0; m_n[k] = 0;
      end else if (m_frz[k] != 0) begin
        m_frz[k] = 0;
      end else if (tk) begin
        d = (scan_code == LC) ? 1 : (scan_code == RC) ? 2 : 0;
        if (d == 0) begin
          m_dir[k] = 0; m_spd[k] = 0; m_n[k] = 0;
        end else begin
          if (d != m_dir[k]) begin
            m_dir[k] = d; m_spd[k] = 1; m_n[k] = 1;
          end else if (m_n[k] == ACC && m_spd[k] < MAXS) begin
            m_spd[k] = m_spd[k] + 1; m_n[k] = 1;
          end else if (m_n[k] < ACC) begin
            m_n[k] = m_n[k] + 1;
          end
          if (d == 1) m_pos[k] = (m_pos[k] - m_spd[k] < 0) ? 0 : m_pos[k] - m_spd[k];
          else        m_pos[k] = (m_pos[k] + m_spd[k] > 560) ? 560 : m_pos[k] + m_spd[k];
        end
      end
    end
    m_cnt = (reset || restart) ? 0 : (m_cnt + 1) % TD;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; freeze = 1'b0; restart = 1'b0; scan_code = 8'h00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (a_begin !== 11'd340 || a_end !== 11'd420 || a_speed !== 3'd0 || a_moving !== 1'b0 ||
        a_at_left !== 1'b0 || a_at_right !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: begin=%0d end=%0d speed=%0d moving=%b l=%b r=%b, want 340 420 0 0 0 0",
               a_begin, a_end, a_speed, a_moving, a_at_left, a_at_right);
    end
    checks++;
    if (b_begin !== 11'd2 || b_end !== 11'd82 || b_at_left !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: begin=%0d end=%0d l=%b, want 2 82 0", b_begin, b_end, b_at_left);
    end
  endtask

  task automatic test_first_move();
    do_reset();
    scan_code = LC;
    cycles(3);
    checks++;
    if (a_begin !== 11'd340) begin
      errors++;
      $display("FAIL early_move: begin=%0d after 3 cycles, want 340", a_begin);
    end
    cycles(1);
    checks++;
    if (a_begin !== 11'd339 || a_end !== 11'd419 || a_speed !== 3'd1 || a_moving !== 1'b1) begin
      errors++;
      $display("FAIL first_move: begin=%0d end=%0d speed=%0d moving=%b, want 339 419 1 1",
               a_begin, a_end, a_speed, a_moving);
    end
  endtask

  task automatic test_accel();
    int steps [8] = '{1, 1, 2, 2, 3, 3, 4, 4};
    int pos = 340;
    do_reset();
    scan_code = RC;
    for (int i = 0; i < 8; i++) begin
      cycles(TD);
      pos += steps[i];
      checks++;
      if (a_begin !== 11'(pos) || a_speed !== 3'(steps[i])) begin
        errors++;
        $display("FAIL accel_tick%0d: begin=%0d speed=%0d, want %0d %0d",
                 i, a_begin, a_speed, pos, steps[i]);
      end
    end
  endtask

  task automatic test_clamp_left();
    do_reset();
    scan_code = LC;
    cycles(8 * TD);
    checks++;
    if (b_begin !== 11'd0 || b_end !== 11'd80 || b_at_left !== 1'b1 || b_speed !== 3'd4 ||
        b_moving !== 1'b1) begin
      errors++;
      $display("FAIL clamp_left: begin=%0d end=%0d l=%b speed=%0d moving=%b, want 0 80 1 4 1",
               b_begin, b_end, b_at_left, b_speed, b_moving);
    end
  endtask

  task automatic test_clamp_right();
    do_reset();
    scan_code = RC;
    cycles(60 * TD);
    checks++;
    if (a_begin !== 11'd560 || a_end !== 11'd640 || a_at_right !== 1'b1 || a_speed !== 3'd4 ||
        a_moving !== 1'b1) begin
      errors++;
      $display("FAIL clamp_right: begin=%0d end=%0d r=%b speed=%0d moving=%b, want 560 640 1 4 1",
               a_begin, a_end, a_at_right, a_speed, a_moving);
    end
    scan_code = LC;
    cycles(TD);
    checks++;
    if (a_begin !== 11'd559 || a_speed !== 3'd1 || a_at_right !== 1'b0) begin
      errors++;
      $display("FAIL reverse: begin=%0d speed=%0d r=%b, want 559 1 0", a_begin, a_speed, a_at_right);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    scan_code = RC;
    cycles(5 * TD);
    checks++;
    if (a_begin !== 11'd349 || a_speed !== 3'd3) begin
      errors++;
      $display("FAIL pre_freeze: begin=%0d speed=%0d, want 349 3", a_begin, a_speed);
    end
    freeze = 1'b1;
    cycles(10 * TD);
    checks++;
    if (a_begin !== 11'd349 || a_speed !== 3'd0 || a_moving !== 1'b0) begin
      errors++;
      $display("FAIL frozen: begin=%0d speed=%0d moving=%b, want 349 0 0", a_begin, a_speed, a_moving);
    end
    freeze = 1'b0;
    cycles(TD);
    checks++;
    if (a_begin !== 11'd350 || a_speed !== 3'd1 || a_moving !== 1'b1) begin
      errors++;
      $display("FAIL unfreeze: begin=%0d speed=%0d moving=%b, want 350 1 1", a_begin, a_speed, a_moving);
    end
  endtask

  task automatic test_restart_on_tick();
    do_reset();
    scan_code = LC;
    cycles(2 * TD + 3);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checks++;
    if (a_begin !== 11'd340 || a_end !== 11'd420 || a_speed !== 3'd0 || a_moving !== 1'b0) begin
      errors++;
      $display("FAIL restart_tick: begin=%0d end=%0d speed=%0d moving=%b, want 340 420 0 0",
               a_begin, a_end, a_speed, a_moving);
    end
    cycles(TD);
    checks++;
    if (a_begin !== 11'd339 || a_speed !== 3'd1) begin
      errors++;
      $display("FAIL after_restart: begin=%0d speed=%0d, want 339 1", a_begin, a_speed);
    end
  endtask

  task automatic test_random();
    logic [27:0] exp_v, got_v;
    logic [7:0] codes [4];
    codes[0] = LC; codes[1] = RC; codes[2] = 8'h00; codes[3] = 8'h1C;
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        exp_v = {11'(m_pos[k]), 11'(m_pos[k] + 80), 3'(m_spd[k]), m_dir[k] != 0,
                 m_pos[k] == 0, m_pos[k] + 80 == 640};
        got_v = (k == 0) ? {a_begin, a_end, a_speed, a_moving, a_at_left, a_at_right}
                         : {b_begin, b_end, b_speed, b_moving, b_at_left, b_at_right};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL random_inst%0d cycle %0d: got %h want %h", k, i, got_v, exp_v);
        end
      end
      reset   = ($urandom_range(0, 999) < 2);
      restart = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 149) == 0) freeze = ~freeze;
      if (freeze && $urandom_range(0, 39) == 0) freeze = 1'b0;
      if ($urandom_range(0, 49) == 0) scan_code = codes[$urandom_range(0, 3)];
      else if ($urandom_range(0, 7) == 0) scan_code = codes[$urandom_range(2, 3)] ^ 8'(i);
    end
  endtask

  initial begin
    reset = 1'b1; freeze = 1'b0; restart = 1'b0; scan_code = 8'h00;
    cycles(2);
    test_reset();
    test_first_move();
    test_accel();
    test_clamp_left();
    test_clamp_right();
    test_freeze();
    test_restart_on_tick();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
